// File: rtl/mdu_div.sv
// rtl/mdu_div.sv - iterative RV64M divide/remainder unit (radix-2 restoring)
module mdu_div #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic            is_word,
  input  logic [XLEN-1:0] data_rs1,
  input  logic [XLEN-1:0] data_rs2,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state_q, state_d;

  logic            sgn, a_neg, b_neg, div_zero, ovf, special, accept;
  logic [XLEN-1:0] ext_a, ext_b, abs_a, abs_b, min_neg, spec_raw, spec_res;

  logic            rem_sel_q, word_q, neg_quo_q, neg_rem_q;
  logic [XLEN-1:0] div_q, quo_q, rem_q, result_q;
  logic [CW-1:0]   cnt_q;

  logic [XLEN:0]   trial;
  logic [XLEN-1:0] quo_d, rem_d, quo_fin, rem_fin, fin_raw, fin_res;

  // Operand conditioning and special-case detection, all resolved in IDLE.
  always_comb begin
    sgn = ~op[0];
    if (is_word) begin
      ext_a = sgn ? {{HALF{data_rs1[HALF-1]}}, data_rs1[HALF-1:0]}
                  : {{HALF{1'b0}}, data_rs1[HALF-1:0]};
      ext_b = sgn ? {{HALF{data_rs2[HALF-1]}}, data_rs2[HALF-1:0]}
                  : {{HALF{1'b0}}, data_rs2[HALF-1:0]};
      min_neg = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
    end else begin
      ext_a   = data_rs1;
      ext_b   = data_rs2;
      min_neg = {1'b1, {(XLEN-1){1'b0}}};
    end
    a_neg    = sgn & ext_a[XLEN-1];
    b_neg    = sgn & ext_b[XLEN-1];
    abs_a    = a_neg ? -ext_a : ext_a;
    abs_b    = b_neg ? -ext_b : ext_b;
    div_zero = (ext_b == '0);
    ovf      = sgn & (ext_a == min_neg) & (ext_b == '1);
    special  = div_zero | ovf;
    accept   = (state_q == IDLE) & start & ~kill;

    if (div_zero) spec_raw = op[1] ? ext_a : '1;
    else          spec_raw = op[1] ? '0 : ext_a;
    spec_res = is_word ? {{HALF{spec_raw[HALF-1]}}, spec_raw[HALF-1:0]} : spec_raw;
  end

  // One restoring step; a borrow out of the trial subtraction means restore.
  always_comb begin
    trial   = {rem_q, quo_q[XLEN-1]} - {1'b0, div_q};
    quo_d   = {quo_q[XLEN-2:0], ~trial[XLEN]};
    rem_d   = trial[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : trial[XLEN-1:0];
    quo_fin = neg_quo_q ? -quo_d : quo_d;
    rem_fin = neg_rem_q ? -rem_d : rem_d;
    fin_raw = rem_sel_q ? rem_fin : quo_fin;
    fin_res = word_q ? {{HALF{fin_raw[HALF-1]}}, fin_raw[HALF-1:0]} : fin_raw;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = special ? DONE : CALC;
      CALC:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rem_sel_q <= 1'b0;
      word_q    <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else if (accept) begin
      rem_sel_q <= op[1];
      word_q    <= is_word;
      neg_quo_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      div_q     <= abs_b;
      // Word dividends sit in the upper half so the MSB-first shift sees them first.
      quo_q     <= is_word ? (abs_a << HALF) : abs_a;
      rem_q     <= '0;
      cnt_q     <= is_word ? CW'(HALF - 1) : CW'(XLEN - 1);
      if (special) result_q <= spec_res;
    end else if (state_q == CALC && !kill) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) result_q <= fin_res;
    end
  end

  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_mdu_div.sv
// tb/tb_mdu_div.sv - randomized self-checking bench for mdu_div
module tb_mdu_div;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic        is_word = 1'b0;
  logic [63:0] data_rs1 = '0;
  logic [63:0] data_rs2 = '0;
  logic        kill = 1'b0;
  logic        busy, done;
  logic [63:0] result;

  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;
  logic [63:0] exp_result = '0;
  bit          chk_en = 1'b0;
  int          checks = 0;
  int          passes = 0;

  localparam logic [1:0] DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3;

  mdu_div #(.XLEN(64)) dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .is_word(is_word),
    .data_rs1(data_rs1), .data_rs2(data_rs2), .kill(kill),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, expv);
  endtask

  // Reference: RISC-V division semantics expressed with plain arithmetic.
  task automatic model(input logic [1:0] o, input bit w, input logic [63:0] a,
                       input logic [63:0] b, output logic [63:0] res, output bit sp);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, q, r;
    bit sg;
    sg = !o[0];
    if (w) begin
      ua = sg ? {{32{a[31]}}, a[31:0]} : {32'b0, a[31:0]};
      ub = sg ? {{32{b[31]}}, b[31:0]} : {32'b0, b[31:0]};
    end else begin
      ua = a;
      ub = b;
    end
    sa = ua;
    sb = ub;
    sp = 1'b0;
    if (ub == 64'd0) begin
      q = '1; r = ua; sp = 1'b1;
    end else if (sg && sb == -64'sd1 &&
                 ua == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) begin
      q = ua; r = 64'd0; sp = 1'b1;
    end else if (sg) begin
      q = sa / sb; r = sa % sb;
    end else begin
      q = ua / ub; r = ua % ub;
    end
    res = o[1] ? r : q;
    if (w) res = {{32{res[31]}}, res[31:0]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {63'b0, busy}, {63'b0, exp_busy});
      check("done", {63'b0, done}, {63'b0, exp_done});
      check("result", result, exp_result);
    end
  end

  task automatic run_op(input logic [1:0] o, input bit w, input logic [63:0] a,
                        input logic [63:0] b, input int kill_at, input int rst_at,
                        input bit start_in_done);
    logic [63:0] r;
    bit sp;
    int n, d, last;
    model(o, w, a, b, r, sp);
    n = w ? 32 : 64;
    d = sp ? 1 : n + 1;
    last = d + 1;
    if (kill_at > 0) last = kill_at + 2;
    if (rst_at > 0) last = rst_at + 3;
    start = 1'b1; op = o; is_word = w; data_rs1 = a; data_rs2 = b;
    exp_busy = 1'b0; exp_done = 1'b0;
    for (int i = 1; i <= last; i++) begin
      step();
      start = 1'b0;
      kill = 1'b0;
      op = 2'($urandom);
      is_word = 1'($urandom);
      data_rs1 = {$urandom, $urandom};
      data_rs2 = {$urandom, $urandom};
      if (i < d && (kill_at < 0 || i <= kill_at) && (rst_at < 0 || i < rst_at))
        start = ($urandom_range(0, 3) == 0);
      if (i == d && start_in_done && kill_at < 0 && rst_at < 0) start = 1'b1;
      if (i == kill_at) kill = 1'b1;
      if (rst_at > 0 && i == rst_at) rstn = 1'b0;
      if (rst_at > 0 && i == rst_at + 1) rstn = 1'b1;
      if (rst_at > 0 && i >= rst_at) begin
        exp_busy = 1'b0; exp_done = 1'b0; exp_result = '0;
      end else if (kill_at > 0 && i > kill_at) begin
        exp_busy = 1'b0; exp_done = 1'b0;
      end else begin
        exp_busy = !sp && (i <= n);
        exp_done = (i == d);
        if (i == d) exp_result = r;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    logic [63:0] r, a, b;
    bit sp;
    logic [1:0] o;
    bit w;

    model(DIV, 0, 64'd100, 64'd7, r, sp);                   check("pin div", r, 64'd14);
    model(REM, 0, -64'sd7, 64'd2, r, sp);                   check("pin rem", r, '1);
    model(REMU, 0, -64'sd7, 64'd2, r, sp);                  check("pin remu", r, 64'd1);
    model(DIVU, 0, 64'h1234, 64'd0, r, sp);                 check("pin divu0", r, '1);
    model(REMU, 0, 64'h1234, 64'd0, r, sp);                 check("pin remu0", r, 64'h1234);
    model(DIV, 0, 64'h8000_0000_0000_0000, '1, r, sp);      check("pin divovf", r, 64'h8000_0000_0000_0000);
    model(DIV, 1, 64'h8000_0000, 64'hFFFF_FFFF, r, sp);     check("pin divwovf", r, 64'hFFFF_FFFF_8000_0000);
    model(DIV, 1, 64'hDEAD_BEEF_FFFF_FFF9, 64'd2, r, sp);   check("pin divw", r, 64'hFFFF_FFFF_FFFF_FFFD);
    model(DIVU, 1, 64'hFFFF_FFFE, 64'd1, r, sp);            check("pin divuw", r, 64'hFFFF_FFFF_FFFF_FFFE);

    chk_en = 1'b1;
    step();
    step();
    rstn = 1'b1;
    step();

    run_op(DIV,  0, 64'd100, 64'd7, -1, -1, 0);
    run_op(REM,  0, -64'sd7, 64'd2, -1, -1, 0);
    run_op(REMU, 0, -64'sd7, 64'd2, -1, -1, 0);
    run_op(DIVU, 0, 64'h1234, 64'd0, -1, -1, 0);
    run_op(REMU, 0, 64'h1234, 64'd0, -1, -1, 0);
    run_op(DIV,  0, 64'h8000_0000_0000_0000, '1, -1, -1, 0);
    run_op(REM,  0, 64'h8000_0000_0000_0000, '1, -1, -1, 0);
    run_op(DIV,  1, 64'h8000_0000, 64'hFFFF_FFFF, -1, -1, 0);
    run_op(DIV,  1, 64'hDEAD_BEEF_FFFF_FFF9, 64'd2, -1, -1, 0);
    run_op(DIVU, 1, 64'hFFFF_FFFE, 64'd1, -1, -1, 0);
    run_op(DIV,  0, 64'd123456789, 64'd1000, 10, -1, 0);
    run_op(DIV,  0, 64'd987654321, 64'd77, -1, 20, 0);
    run_op(DIVU, 0, 64'd1000, 64'd3, -1, -1, 1);
    run_op(REMU, 1, 64'h1234_5678_9ABC_DEF0, 64'd0, -1, -1, 1);

    for (int k = 0; k < 80; k++) begin
      o = 2'($urandom);
      w = 1'($urandom);
      case ($urandom_range(0, 4))
        0:       a = 64'h8000_0000_0000_0000;
        1:       a = 64'h8000_0000;
        2:       a = 64'($urandom_range(0, 200));
        default: a = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 5))
        0:       b = 64'd0;
        1:       b = '1;
        2:       b = 64'($urandom_range(1, 20));
        3:       b = 64'hFFFF_FFFF;
        4:       b = -64'($urandom_range(1, 20));
        default: b = {$urandom, $urandom} >> $urandom_range(0, 63);
      endcase
      run_op(o, w, a, b, -1, -1, 1'($urandom));
    end

    step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
